// File: rtl/ex_ctrl_pkg.sv
// Shared types and constants for the EX-stage control block.
package ex_ctrl_pkg;

  localparam int MUL_LAT_MAX = 16;
  // Holds MUL_LATENCY-1 for the full legal latency range.
  localparam int CNT_W = $clog2(MUL_LAT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_tracker.sv
// MUL/ACC in-flight tracker: counts down the multiplier latency and marks the
// HI/LO write cycle (state DONE).
module mul_tracker
  import ex_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic       acc_in,
  output mul_state_t state,
  output logic       acc_q
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(MUL_LATENCY - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      cnt   <= '0;
      acc_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            acc_q <= acc_in;
            if (MUL_LATENCY == 1) begin
              state <= DONE;
            end else begin
              state <= BUSY;
              cnt   <= LOAD;
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_control_p.sv
// EX-stage control: GPR write gating, MUL/HI-LO interlock and optional
// branch-likely delay-slot annulment (enabled by EX_CTRL_BRANCH_LIKELY_EN).
module ex_control_p
  import ex_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int DEST_W      = 5
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              InstValid,
  input  logic              Branch,
  input  logic              BranchLikely,
  input  logic              BRAtaken,
  input  logic              RegWriteIn,
  input  logic [DEST_W-1:0] RegDestIn,
  input  logic              MulStart,
  input  logic              AccOp,
  input  logic              HiLoRead,
  output logic              RegWriteOut,
  output logic [DEST_W-1:0] RegDestOut,
  output logic              HiLoWrite,
  output logic              HiLoAcc,
  output logic              MulBusy,
  output logic              Stall,
  output logic              Annul
);

  mul_state_t state;
  logic       issue;

  mul_tracker #(.MUL_LATENCY(MUL_LATENCY)) u_mul_tracker (
    .clk    (clk),
    .nrst   (nrst),
    .start  (issue & MulStart),
    .acc_in (AccOp),
    .state  (state),
    .acc_q  (HiLoAcc)
  );

`ifdef EX_CTRL_BRANCH_LIKELY_EN
  logic annul_pending;

  // A pending annul is consumed by the next valid instruction; bubbles keep it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      annul_pending <= 1'b0;
    end else if (InstValid && annul_pending) begin
      annul_pending <= 1'b0;
    end else if (issue && Branch && BranchLikely && !BRAtaken) begin
      annul_pending <= 1'b1;
    end
  end

  assign Annul = annul_pending;
`else
  logic unused_branch_likely;
  assign unused_branch_likely = BranchLikely;
  assign Annul = 1'b0;
`endif

  // A MUL or HI/LO read must wait while a result is still in flight; a HI/LO
  // read also waits out the write cycle itself.
  assign Stall = InstValid && !Annul && (MulStart || HiLoRead) &&
                 ((state == BUSY) || ((state == DONE) && HiLoRead));

  assign issue       = InstValid && !Stall && !Annul;
  assign RegWriteOut = issue && RegWriteIn && !(Branch && !BRAtaken);
  assign RegDestOut  = RegWriteOut ? RegDestIn : '0;
  assign HiLoWrite   = (state == DONE);
  assign MulBusy     = (state != IDLE);

endmodule

// File: tb/tb_ex_control_p.sv
// Directed bench for ex_control_p: one instance at MUL_LATENCY=4, one at 1.
module tb_ex_control_p;

`ifdef EX_CTRL_BRANCH_LIKELY_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nrst;
  logic       iv, br, bl, tk, rwi, ms, acc, hr;
  logic [4:0] rdi;

  logic       rwo4, hlw4, hla4, busy4, stall4, annul4;
  logic [4:0] rdo4;
  logic       rwo1, hlw1, hla1, busy1, stall1, annul1;
  logic [4:0] rdo1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_control_p #(.MUL_LATENCY(4), .DEST_W(5)) dut4 (
    .clk(clk), .nrst(nrst), .InstValid(iv), .Branch(br), .BranchLikely(bl),
    .BRAtaken(tk), .RegWriteIn(rwi), .RegDestIn(rdi), .MulStart(ms),
    .AccOp(acc), .HiLoRead(hr), .RegWriteOut(rwo4), .RegDestOut(rdo4),
    .HiLoWrite(hlw4), .HiLoAcc(hla4), .MulBusy(busy4), .Stall(stall4),
    .Annul(annul4)
  );

  ex_control_p #(.MUL_LATENCY(1), .DEST_W(5)) dut1 (
    .clk(clk), .nrst(nrst), .InstValid(iv), .Branch(br), .BranchLikely(bl),
    .BRAtaken(tk), .RegWriteIn(rwi), .RegDestIn(rdi), .MulStart(ms),
    .AccOp(acc), .HiLoRead(hr), .RegWriteOut(rwo1), .RegDestOut(rdo1),
    .HiLoWrite(hlw1), .HiLoAcc(hla1), .MulBusy(busy1), .Stall(stall1),
    .Annul(annul1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic l, input logic t,
                       input logic w, input logic [4:0] d, input logic m,
                       input logic a, input logic h);
    iv = v; br = b; bl = l; tk = t; rwi = w; rdi = d; ms = m; acc = a; hr = h;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the
  // falling edge in the middle of the cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    nrst = 1'b0;
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    nrst = 1'b0;
    drive(0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    #12;
    chk("rst_rwo",   {31'd0, rwo4},   32'd0);
    chk("rst_hlw",   {31'd0, hlw4},   32'd0);
    chk("rst_hla",   {31'd0, hla4},   32'd0);
    chk("rst_busy",  {31'd0, busy4},  32'd0);
    chk("rst_stall", {31'd0, stall4}, 32'd0);
    chk("rst_annul", {31'd0, annul4}, 32'd0);
    nrst = 1'b1;
    tick();

    // GPR write gating on branch resolution.
    drive(1, 1, 0, 0, 1, 5'd31, 0, 0, 0); sample();
    chk("br_nt_rwo", {31'd0, rwo4}, 32'd0);
    chk("br_nt_rdo", {27'd0, rdo4}, 32'd0);
    tick();
    drive(1, 1, 0, 1, 1, 5'd31, 0, 0, 0); sample();
    chk("br_tk_rwo", {31'd0, rwo4}, 32'd1);
    chk("br_tk_rdo", {27'd0, rdo4}, 32'd31);
    tick();
    drive(1, 0, 0, 0, 1, 5'd7, 0, 0, 0); sample();
    chk("alu_rwo", {31'd0, rwo4}, 32'd1);
    chk("alu_rdo", {27'd0, rdo4}, 32'd7);
    tick();
    drive(0, 0, 0, 0, 1, 5'd7, 0, 0, 0); sample();
    chk("bubble_rwo", {31'd0, rwo4}, 32'd0);
    chk("bubble_rdo", {27'd0, rdo4}, 32'd0);
    tick();

    // MUL_LATENCY=4: issue at c0, second MUL stalls c2..c3, issues at c4.
    drive(1, 0, 0, 0, 0, 5'd0, 1, 1, 0); sample();                  // c0
    chk("c0_busy", {31'd0, busy4}, 32'd0);
    chk("c0_stall", {31'd0, stall4}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 5'd0, 0, 0, 0); sample();                  // c1
    chk("c1_busy", {31'd0, busy4}, 32'd1);
    chk("c1_hlw", {31'd0, hlw4}, 32'd0);
    tick();
    drive(1, 0, 0, 0, 1, 5'd5, 1, 0, 0); sample();                  // c2
    chk("c2_stall", {31'd0, stall4}, 32'd1);
    chk("c2_rwo", {31'd0, rwo4}, 32'd0);
    chk("c2_rdo", {27'd0, rdo4}, 32'd0);
    chk("c2_hlw", {31'd0, hlw4}, 32'd0);
    tick(); sample();                                                // c3
    chk("c3_stall", {31'd0, stall4}, 32'd1);
    chk("c3_busy", {31'd0, busy4}, 32'd1);
    chk("c3_hlw", {31'd0, hlw4}, 32'd0);
    tick(); sample();                                                // c4
    chk("c4_hlw", {31'd0, hlw4}, 32'd1);
    chk("c4_hla", {31'd0, hla4}, 32'd1);
    chk("c4_busy", {31'd0, busy4}, 32'd1);
    chk("c4_stall", {31'd0, stall4}, 32'd0);
    chk("c4_rwo", {31'd0, rwo4}, 32'd1);
    chk("c4_rdo", {27'd0, rdo4}, 32'd5);
    tick();
    drive(0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    for (int c = 5; c <= 7; c++) begin
      sample();
      chk($sformatf("c%0d_busy", c), {31'd0, busy4}, 32'd1);
      chk($sformatf("c%0d_hlw", c), {31'd0, hlw4}, 32'd0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 5'd0, 0, 0, 1); sample();                  // c8, MFHI in DONE
    chk("c8_hlw", {31'd0, hlw4}, 32'd1);
    chk("c8_hla", {31'd0, hla4}, 32'd0);
    chk("c8_stall", {31'd0, stall4}, 32'd1);
    tick(); sample();                                                // c9
    chk("c9_stall", {31'd0, stall4}, 32'd0);
    chk("c9_busy", {31'd0, busy4}, 32'd0);
    chk("c9_hlw", {31'd0, hlw4}, 32'd0);
    tick();

    // MUL_LATENCY=1 instance.
    reset_pulse();
    drive(1, 0, 0, 0, 0, 5'd0, 1, 1, 0); sample();
    chk("l1_c0_busy", {31'd0, busy1}, 32'd0);
    tick();
    drive(1, 0, 0, 0, 0, 5'd0, 0, 0, 1); sample();
    chk("l1_c1_hlw", {31'd0, hlw1}, 32'd1);
    chk("l1_c1_hla", {31'd0, hla1}, 32'd1);
    chk("l1_c1_stall", {31'd0, stall1}, 32'd1);
    tick(); sample();
    chk("l1_c2_stall", {31'd0, stall1}, 32'd0);
    chk("l1_c2_hlw", {31'd0, hlw1}, 32'd0);
    chk("l1_c2_busy", {31'd0, busy1}, 32'd0);
    tick();

    // Asynchronous reset in the middle of a MUL.
    reset_pulse();
    drive(1, 0, 0, 0, 0, 5'd0, 1, 1, 0); tick();                    // c0 issued
    drive(0, 0, 0, 0, 0, 5'd0, 0, 0, 0); tick();                    // c1
    sample();                                                        // c2
    chk("mr_busy_pre", {31'd0, busy4}, 32'd1);
    nrst = 1'b0;
    #1;
    chk("mr_busy", {31'd0, busy4}, 32'd0);
    chk("mr_hlw", {31'd0, hlw4}, 32'd0);
    chk("mr_hla", {31'd0, hla4}, 32'd0);
    chk("mr_stall", {31'd0, stall4}, 32'd0);
    chk("mr_annul", {31'd0, annul4}, 32'd0);
    chk("mr_rwo", {31'd0, rwo4}, 32'd0);
    nrst = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      sample();
      chk($sformatf("mr_after%0d_hlw", c), {31'd0, hlw4}, 32'd0);
      tick();
    end

    // Branch-likely not taken, one bubble, then the delay-slot instruction.
    reset_pulse();
    drive(1, 1, 1, 0, 0, 5'd0, 0, 0, 0); sample();
    chk("bl_br_annul", {31'd0, annul4}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 5'd0, 0, 0, 0); sample();
    chk("bl_bub_annul", {31'd0, annul4}, {31'd0, BL});
    tick(); sample();
    chk("bl_bub2_annul", {31'd0, annul4}, {31'd0, BL});
    tick();
    drive(1, 0, 0, 0, 1, 5'd9, 1, 0, 0); sample();
    chk("bl_ds_annul", {31'd0, annul4}, {31'd0, BL});
    chk("bl_ds_rwo", {31'd0, rwo4}, {31'd0, !BL});
    chk("bl_ds_rdo", {27'd0, rdo4}, BL ? 32'd0 : 32'd9);
    chk("bl_ds_stall", {31'd0, stall4}, 32'd0);
    tick();
    drive(1, 0, 0, 0, 1, 5'd9, 0, 0, 0); sample();
    chk("bl_next_annul", {31'd0, annul4}, 32'd0);
    chk("bl_next_rwo", {31'd0, rwo4}, 32'd1);
    chk("bl_next_rdo", {27'd0, rdo4}, 32'd9);
    chk("bl_next_busy", {31'd0, busy4}, {31'd0, !BL});
    tick();
    drive(1, 1, 1, 1, 0, 5'd0, 0, 0, 0); tick();                    // taken: no annul
    drive(1, 0, 0, 0, 1, 5'd3, 0, 0, 0); sample();
    chk("blt_ds_annul", {31'd0, annul4}, 32'd0);
    chk("blt_ds_rwo", {31'd0, rwo4}, 32'd1);
    chk("blt_ds_rdo", {27'd0, rdo4}, 32'd3);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_control_p.md
EX_CONTROL_P -- requirements
Module: ex_control_p

Interface
REQ-001 The block SHALL have parameter MUL_LATENCY, default 4: cycles from MUL/ACC issue to HI/LO write, legal range 1..16.
REQ-002 The block SHALL have parameter DEST_W, default 5: destination register index width.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 nrst  input  1  asynchronous, active-low reset.
REQ-005 InstValid  input  1  the instruction presented in EX is valid.
REQ-006 Branch  input  1  the EX instruction is a branch.
REQ-007 BranchLikely  input  1  the EX branch is a branch-likely (delay slot annulled if not taken).
REQ-008 BRAtaken  input  1  branch condition resolved taken.
REQ-009 RegWriteIn  input  1  the decoded instruction writes the GPR file.
REQ-010 RegDestIn  input  DEST_W  GPR destination index.
REQ-011 MulStart  input  1  the EX instruction issues a MUL/ACC operation.
REQ-012 AccOp  input  1  with MulStart: accumulate into HI/LO rather than overwrite.
REQ-013 HiLoRead  input  1  the EX instruction reads HI/LO (MFHI/MFLO).
REQ-014 RegWriteOut  output  1  gated GPR write enable.
REQ-015 RegDestOut  output  DEST_W  RegDestIn, forced to 0 when RegWriteOut=0.
REQ-016 HiLoWrite  output  1  one-cycle HI/LO write strobe.
REQ-017 HiLoAcc  output  1  captured AccOp, valid with HiLoWrite.
REQ-018 MulBusy  output  1  a MUL/ACC is in flight.
REQ-019 Stall  output  1  hold EX and upstream stages this cycle.
REQ-020 Annul  output  1  the current EX instruction is a squashed delay slot.

Function
REQ-021 "issue" SHALL mean InstValid & !Stall & !Annul.
REQ-022 RegWriteOut SHALL be combinational: issue & RegWriteIn & !(Branch & !BRAtaken).
REQ-023 Stall SHALL be 1 when InstValid & !Annul & (MulStart | HiLoRead) and the FSM is in BUSY, or in DONE with HiLoRead.
REQ-024 The MUL tracker FSM SHALL have states IDLE, BUSY, DONE.
REQ-025 IDLE->BUSY on issue & MulStart, loading the counter with MUL_LATENCY-1 and capturing AccOp; when MUL_LATENCY=1, IDLE->DONE directly.
REQ-026 In BUSY, the counter SHALL decrement each cycle; at counter=1 the next state SHALL be DONE.
REQ-027 In DONE, HiLoWrite=1 for exactly that cycle; next state SHALL be BUSY (counter reloaded) on issue & MulStart, otherwise IDLE.
REQ-028 MulBusy SHALL be 1 in BUSY and DONE.
REQ-029 A stalled instruction SHALL cause no state change; upstream holds inputs stable until Stall=0.
REQ-030 An issued BranchLikely with !BRAtaken SHALL set annul_pending on the next edge; Annul = annul_pending.
REQ-031 annul_pending SHALL clear on the first subsequent cycle with InstValid; cycles with InstValid=0 SHALL hold it.
REQ-032 An annulled instruction SHALL not write GPRs, start a MUL, raise Stall, or set annul_pending.

Reset
REQ-033 On nrst=0, the block SHALL immediately force FSM=IDLE, counter=0, annul_pending=0 and captured AccOp=0.
REQ-034 Reset mid-MUL SHALL abandon the operation with no HiLoWrite; outputs SHALL be RegWriteOut=0, HiLoWrite=0, HiLoAcc=0, MulBusy=0, Stall=0, Annul=0 (with InstValid=0).

Configuration
REQ-035 When EX_CTRL_BRANCH_LIKELY_EN is defined, REQ-030..032 SHALL apply.
REQ-036 When EX_CTRL_BRANCH_LIKELY_EN is undefined, BranchLikely SHALL be ignored, annul_pending SHALL not exist, and Annul SHALL be tied to 0.

Structure
REQ-037 Package ex_ctrl_pkg SHALL hold the mul_state_t enum (IDLE, BUSY, DONE) and the constant MUL_LAT_MAX=16.
REQ-038 The FSM and counter SHALL live in sub-module mul_tracker; ex_control_p holds the gating and annul logic.

Verification
REQ-039 Branch=1, BRAtaken=0, RegWriteIn=1, RegDestIn=31 -> RegWriteOut=0, RegDestOut=0; with BRAtaken=1 -> RegWriteOut=1, RegDestOut=31.
REQ-040 MUL_LATENCY=4, MulStart issued at cycle 0 -> MulBusy=1 during cycles 1..4, HiLoWrite=1 at cycle 4 only.
REQ-041 Second MulStart at cycle 2 -> Stall=1 during cycles 2..3; issues at cycle 4 (DONE) -> HiLoWrite cycles 4 and 8.
REQ-042 Macro defined: BranchLikely not taken, then one InstValid=0 bubble, then RegWriteIn=1 -> Annul=1 on that instruction, RegWriteOut=0; next instruction writes normally.
REQ-043 MUL_LATENCY=1: MulStart at cycle 0 -> HiLoWrite at cycle 1; HiLoRead at cycle 1 -> Stall=1.
REQ-044 nrst pulsed low at cycle 2 of a MUL_LATENCY=4 operation -> MulBusy=0 immediately; no HiLoWrite follows.
